alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Accumulator-based command sequencer that sits directly upstream of the 4-bit ALU and consumes its Result/Overflow.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- For each command it drives the ALU operands and control from an internal accumulator, captures the ALU output back into the accumulator, and returns a response over a second valid/ready handshake.
- Maintains a sticky overflow flag for software.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >= 2)
- PTR_W, 2, FIFO pointer width = log2(DEPTH)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept (not full)
- cmd_load  input  1  1 = load accumulator with cmd_data; 0 = ALU op
- cmd_op  input  2  ALU control code: 00 AND, 01 ADD, 10 AND, 11 SUB
- cmd_data  input  4  operand B (or load value)
- alu_opA  output  4  registered operand A to ALU (accumulator value)
- alu_opB  output  4  registered operand B to ALU
- alu_ctrl  output  2  registered ALU control
- alu_result  input  4  ALU Result (combinational from alu_* outputs)
- alu_overflow  input  1  ALU Overflow
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  4  new accumulator value
- rsp_ovf  output  1  overflow for this command
- acc  output  4  current accumulator
- sticky_ovf  output  1  set on any captured overflow
- clr_sticky  input  1  clears sticky_ovf

Behaviour:
- Reset (rst_n=0, async): FIFO emptied, FSM=IDLE, and all of acc, alu_opA, alu_opB, alu_ctrl, rsp_data, rsp_ovf, rsp_valid and sticky_ovf are 0. cmd_ready=1 once out of reset.
- Reset asserted mid-command drops the in-flight command and all queued commands; no response is produced.
- Command accept: a command is accepted on a clk edge with cmd_valid & cmd_ready.
  - cmd_ready = !full; it does not depend on cmd_valid.
  - Full: cmd_valid is ignored and no entry is written.
  - Simultaneous push and pop while full: the push is refused, because cmd_ready is computed from the pre-pop state.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head and load alu_opA<=acc, alu_opB<=cmd_data, alu_ctrl<=cmd_op. Latch the load flag and load value. Go to EXEC.
  - EXEC (exactly 1 cycle; the ALU settles combinationally):
    - ALU op: acc<=alu_result, rsp_data<=alu_result, rsp_ovf<=alu_overflow.
    - Load: acc<=cmd_data, rsp_data<=cmd_data, rsp_ovf<=0; ALU output is ignored.
    - Set rsp_valid<=1 and go to RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_ovf stable until rsp_ready=1. On that edge, rsp_valid<=0 and go to IDLE.
- Latency and throughput:
  - Command pushed into an empty FIFO at edge N: EXEC during cycle N+1 to N+2, rsp_valid high from edge N+2.
  - Minimum of 3 cycles per command.
- Arithmetic: all values are 4-bit, wrap modulo 16.
  - ALU overflow is signed two's-complement overflow on ADD/SUB and 0 on AND.
  - The sequencer does not recompute overflow; it samples alu_overflow.
- Sticky flag: sticky_ovf<=1 in EXEC when rsp_ovf is captured as 1. clr_sticky clears it. If set and clear occur in the same cycle, set wins.
- FIFO wrap: pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- alu_* outputs hold their last values outside EXEC.

Decomposition:
- Shared package/header: ALU opcode constants (OP_AND0=2'b00, OP_ADD=2'b01, OP_AND1=2'b10, OP_SUB=2'b11); FSM state encoding IDLE/EXEC/RESP; command word layout {load, op[1:0], data[3:0]} = 7 bits.
- Sub-module: cmd_fifo (synchronous, DEPTH x 7, async active-low reset, full/empty flags).

Test Plan:
- Reset mid-flight:
  - Stimulus: push load 5, then assert rst_n=0 during EXEC.
  - Response: acc=0, rsp_valid=0, cmd_ready=1, and no response after release.
- Load then ADD with overflow:
  - Stimulus: load 5 (rsp 5, ovf 0), then ADD 3 with rsp_ready=1.
  - Response: rsp_data=8, rsp_ovf=1, sticky_ovf=1, acc=8.
  - rsp_valid must rise exactly 2 edges after accept.
- SUB and AND sequence:
  - Stimulus: acc=8; SUB 1 -> rsp 7, ovf 1. Then load 12 and AND 10.
  - Response: rsp 8, ovf 0.
  - Also check the alias: op 10 with data 3 on acc 7 gives 3.
- FIFO full and backpressure:
  - Stimulus: rsp_ready=0, push DEPTH+2 commands.
  - Response: cmd_ready drops after 1+DEPTH accepts (one in RESP, DEPTH queued); extra cmd_valid is ignored.
  - rsp_data stays stable while stalled; releasing rsp_ready drains all commands in order.
- Sticky priority:
  - Stimulus: clr_sticky=1 in the same cycle as an overflowing ADD captures (7+1).
  - Response: sticky_ovf=1. A clr_sticky pulse in a later cycle clears it to 0.
- Wrap-around:
  - Stimulus: ADD 1 on acc=15.
  - Response: rsp 0, ovf 0. Then issue 3xDEPTH back-to-back commands to check pointer wrap and ordering.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// and the command word layout stored in the FIFO.
package alu_cmd_sequencer_pkg;

  localparam logic [1:0] OP_AND0 = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND1 = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam int CMD_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // {load, op[1:0], data[3:0]}
  typedef struct packed {
    logic       load;
    logic [1:0] op;
    logic [3:0] data;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  // Requests are qualified here so a caller can never corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // Pointer update; natural overflow of PTR_W+1 bits gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-based sequencer feeding an external combinational 4-bit ALU.
// Each command takes IDLE (issue) -> EXEC (capture) -> RESP (handshake).
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_opA,
  output logic [3:0] alu_opB,
  output logic [1:0] alu_ctrl,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_ovf,
  output logic [3:0] acc,
  output logic       sticky_ovf,
  input  logic       clr_sticky
);

  cmd_t       wr_cmd, rd_cmd;
  logic       full, empty, push, pop;
  state_t     state, state_nxt;
  logic       ld_flag;
  logic [3:0] ld_val;
  logic [3:0] cap_data;
  logic       cap_ovf;

  // Ready reflects pre-pop occupancy, so a push against a full FIFO is
  // refused even when the same edge pops.
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;

  assign wr_cmd.load = cmd_load;
  assign wr_cmd.op   = cmd_op;
  assign wr_cmd.data = cmd_data;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (rd_cmd),
    .full  (full),
    .empty (empty)
  );

  // Loads bypass the ALU; ALU ops take whatever the ALU settled to.
  assign cap_data = ld_flag ? ld_val : alu_result;
  assign cap_ovf  = ~ld_flag & alu_overflow;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and FIFO pop decode.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand issue on pop, result capture in EXEC, response handshake in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opA   <= '0;
      alu_opB   <= '0;
      alu_ctrl  <= '0;
      ld_flag   <= 1'b0;
      ld_val    <= '0;
      acc       <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_opA  <= acc;
        alu_opB  <= rd_cmd.data;
        alu_ctrl <= rd_cmd.op;
        ld_flag  <= rd_cmd.load;
        ld_val   <= rd_cmd.data;
      end
      if (state == ST_EXEC) begin
        acc       <= cap_data;
        rsp_data  <= cap_data;
        rsp_ovf   <= cap_ovf;
        rsp_valid <= 1'b1;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow: a capture in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           sticky_ovf <= 1'b0;
    else if (state == ST_EXEC && cap_ovf) sticky_ovf <= 1'b1;
    else if (clr_sticky)                  sticky_ovf <= 1'b0;
  end

endmodule
